// File: rtl/efuse_array_emu.sv
// Emulation model of the 256-bit eFuse macro: OTP storage, program/read pulse
// timing checks and a sticky protocol-error flag for controller verification.
module efuse_array_emu #(
    parameter int unsigned  TPGM_MIN = 8,
    parameter int unsigned  TRD      = 2,
    parameter logic [255:0] INIT     = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       efuse_pgmen_i,
    input  logic       efuse_rden_i,
    input  logic       efuse_aen_i,
    input  logic [7:0] efuse_addr_i,
    output logic [7:0] efuse_rdata_o,
    output logic       pgm_done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    input  logic       err_clr_i
);

    localparam int unsigned   CMAX    = (TPGM_MIN > TRD) ? TPGM_MIN : TRD;
    localparam int unsigned   CW      = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PGM_LIM = CW'(TPGM_MIN);
    localparam logic [CW-1:0] RD_LIM  = CW'(TRD);

    typedef enum logic [1:0] {IDLE, PGM, RD, WAIT_LOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aen_q;
    logic          pgmen_q, rden_q;
    logic [7:0]    addr_q;
    logic [255:0]  fuse;

    logic          latch, do_write, do_load, done_d, err_set;
    logic [1:0]    err_code_d;
    logic          ctrl_changed;
    logic [4:0]    load_byte;

    assign ctrl_changed = (efuse_pgmen_i != pgmen_q) || (efuse_rden_i != rden_q) ||
                          (efuse_addr_i != addr_q);
    // With TRD=1 the load happens at E, before the address is latched.
    assign load_byte    = latch ? efuse_addr_i[7:3] : addr_q[7:3];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        do_write   = 1'b0;
        do_load    = 1'b0;
        done_d     = 1'b0;
        err_set    = 1'b0;
        err_code_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (efuse_aen_i && !aen_q) begin
                    latch = 1'b1;
                    if (efuse_pgmen_i && !efuse_rden_i) begin
                        state_d = PGM;
                        cnt_d   = CW'(1);
                    end else if (!efuse_pgmen_i && efuse_rden_i) begin
                        state_d = RD;
                        cnt_d   = CW'(1);
                        do_load = (RD_LIM == CW'(1));
                    end else begin
                        err_set    = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = WAIT_LOW;
                    end
                end
            end
            PGM: begin
                if (efuse_aen_i) begin
                    if (ctrl_changed) begin
                        err_set    = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = WAIT_LOW;
                        cnt_d      = '0;
                    end else if (cnt_q < PGM_LIM) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    if (cnt_q >= PGM_LIM) begin
                        do_write = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        err_set    = 1'b1;
                        err_code_d = 2'b10;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            RD: begin
                if (efuse_aen_i) begin
                    if (ctrl_changed) begin
                        err_set    = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = WAIT_LOW;
                        cnt_d      = '0;
                    end else if (cnt_q < RD_LIM) begin
                        cnt_d   = cnt_q + CW'(1);
                        do_load = ((cnt_q + CW'(1)) == RD_LIM);
                    end
                end else begin
                    if (cnt_q < RD_LIM) begin
                        err_set    = 1'b1;
                        err_code_d = 2'b10;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (!efuse_aen_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            aen_q         <= 1'b0;
            pgmen_q       <= 1'b0;
            rden_q        <= 1'b0;
            addr_q        <= '0;
            fuse          <= INIT;
            efuse_rdata_o <= '0;
            pgm_done_o    <= 1'b0;
            err_o         <= 1'b0;
            err_code_o    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aen_q      <= efuse_aen_i;
            pgm_done_o <= done_d;
            if (latch) begin
                pgmen_q <= efuse_pgmen_i;
                rden_q  <= efuse_rden_i;
                addr_q  <= efuse_addr_i;
            end
            if (do_write) begin
                fuse[addr_q] <= 1'b1;
            end
            if (do_load) begin
                efuse_rdata_o <= fuse[{load_byte, 3'b000} +: 8];
            end
            if (err_set) begin
                err_o <= 1'b1;
                if (!err_o || err_clr_i) begin
                    err_code_o <= err_code_d;
                end
            end else if (err_clr_i) begin
                err_o      <= 1'b0;
                err_code_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_efuse_array_emu.sv
// Directed self-checking bench for efuse_array_emu (TPGM_MIN=8, TRD=2,
// INIT has byte 0 = 0xFF).
module tb_efuse_array_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       efuse_pgmen_i;
    logic       efuse_rden_i;
    logic       efuse_aen_i;
    logic [7:0] efuse_addr_i;
    logic [7:0] efuse_rdata_o;
    logic       pgm_done_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic       err_clr_i;

    int n_chk  = 0;
    int n_pass = 0;

    efuse_array_emu #(
        .TPGM_MIN(8),
        .TRD     (2),
        .INIT    (256'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .efuse_pgmen_i(efuse_pgmen_i),
        .efuse_rden_i (efuse_rden_i),
        .efuse_aen_i  (efuse_aen_i),
        .efuse_addr_i (efuse_addr_i),
        .efuse_rdata_o(efuse_rdata_o),
        .pgm_done_o   (pgm_done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Program pulse of w high cycles; returns pgm_done_o at F+1 and F+2.
    task automatic pgm(input logic [7:0] a, input int w, output logic d1, output logic d2);
        efuse_pgmen_i = 1'b1;
        efuse_rden_i  = 1'b0;
        efuse_addr_i  = a;
        efuse_aen_i   = 1'b0;
        step();
        efuse_aen_i = 1'b1;
        repeat (w) step();
        efuse_aen_i = 1'b0;
        step();
        d1 = pgm_done_o;
        step();
        d2 = pgm_done_o;
        efuse_pgmen_i = 1'b0;
    endtask

    // Read pulse of h high cycles; returns rdata seen in cycle E+2 (h >= 2).
    task automatic rd(input logic [7:0] a, input int h, output logic [7:0] d);
        d             = efuse_rdata_o;
        efuse_rden_i  = 1'b1;
        efuse_pgmen_i = 1'b0;
        efuse_addr_i  = a;
        efuse_aen_i   = 1'b0;
        step();
        efuse_aen_i = 1'b1;
        for (int i = 0; i < h; i++) begin
            step();
            if (i == 1) d = efuse_rdata_o;
        end
        efuse_aen_i = 1'b0;
        step();
        efuse_rden_i = 1'b0;
    endtask

    initial begin
        logic       d1, d2;
        logic [7:0] rdv;

        rst_n         = 1'b0;
        efuse_pgmen_i = 1'b0;
        efuse_rden_i  = 1'b0;
        efuse_aen_i   = 1'b0;
        efuse_addr_i  = '0;
        err_clr_i     = 1'b0;
        repeat (3) step();
        chk("rst_rdata", efuse_rdata_o, 8'h00);
        chk("rst_done", {7'b0, pgm_done_o}, 8'h00);
        chk("rst_err", {7'b0, err_o}, 8'h00);
        chk("rst_code", {6'b0, err_code_o}, 8'h00);
        rst_n = 1'b1;
        repeat (2) step();

        // Valid program of bit 0x13, then read its byte.
        pgm(8'h13, 8, d1, d2);
        chk("pgm8_done_f1", {7'b0, d1}, 8'h01);
        chk("pgm8_done_f2", {7'b0, d2}, 8'h00);
        chk("pgm8_err", {7'b0, err_o}, 8'h00);
        rd(8'h10, 3, rdv);
        chk("rd_byte2", rdv, 8'h08);
        chk("rd_byte2_err", {7'b0, err_o}, 8'h00);

        // Short program pulse on bit 0x14.
        pgm(8'h14, 7, d1, d2);
        chk("pgm7_done", {7'b0, d1}, 8'h00);
        chk("pgm7_err", {7'b0, err_o}, 8'h01);
        chk("pgm7_code", {6'b0, err_code_o}, 8'h02);
        rd(8'h10, 3, rdv);
        chk("pgm7_nowrite", rdv, 8'h08);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("clr_err", {7'b0, err_o}, 8'h00);
        chk("clr_code", {6'b0, err_code_o}, 8'h00);

        // Reprogramming an already-blown bit.
        pgm(8'h02, 8, d1, d2);
        chk("otp_done", {7'b0, d1}, 8'h01);
        rd(8'h00, 3, rdv);
        chk("otp_byte0", rdv, 8'hFF);

        // Mode conflict at E.
        efuse_pgmen_i = 1'b1;
        efuse_rden_i  = 1'b1;
        efuse_addr_i  = 8'h30;
        efuse_aen_i   = 1'b0;
        step();
        efuse_aen_i = 1'b1;
        step();
        chk("conf_err", {7'b0, err_o}, 8'h01);
        chk("conf_code", {6'b0, err_code_o}, 8'h01);
        step();
        efuse_aen_i = 1'b0;
        step();
        efuse_pgmen_i = 1'b0;
        efuse_rden_i  = 1'b0;
        step();
        rd(8'h30, 3, rdv);
        chk("conf_nowrite", rdv, 8'h00);
        // Short read: new error must not overwrite first code, rdata held.
        rd(8'h00, 1, rdv);
        chk("shortrd_err", {7'b0, err_o}, 8'h01);
        chk("shortrd_code_kept", {6'b0, err_code_o}, 8'h01);
        chk("shortrd_rdata_held", efuse_rdata_o, 8'h00);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("clr2_err", {7'b0, err_o}, 8'h00);
        rd(8'h00, 3, rdv);
        chk("after_clr_rd", rdv, 8'hFF);

        // Address change at E+3 of a program pulse.
        efuse_pgmen_i = 1'b1;
        efuse_rden_i  = 1'b0;
        efuse_addr_i  = 8'h20;
        efuse_aen_i   = 1'b0;
        step();
        efuse_aen_i = 1'b1;
        repeat (3) step();
        efuse_addr_i = 8'h21;
        step();
        chk("chg_err", {7'b0, err_o}, 8'h01);
        chk("chg_code", {6'b0, err_code_o}, 8'h03);
        efuse_addr_i = 8'h20;
        repeat (6) step();
        efuse_aen_i = 1'b0;
        step();
        chk("chg_nodone_f1", {7'b0, pgm_done_o}, 8'h00);
        step();
        chk("chg_nodone_f2", {7'b0, pgm_done_o}, 8'h00);
        efuse_pgmen_i = 1'b0;
        rd(8'h20, 3, rdv);
        chk("chg_nowrite", rdv, 8'h00);

        // Error coinciding with clear loads the new code.
        err_clr_i = 1'b1;
        rd(8'h10, 1, rdv);
        err_clr_i = 1'b0;
        chk("errclr_err", {7'b0, err_o}, 8'h01);
        chk("errclr_code", {6'b0, err_code_o}, 8'h02);
        rd(8'h10, 3, rdv);
        chk("pre_rst_rd", rdv, 8'h08);

        // Reset at E+4 of a program pulse.
        efuse_pgmen_i = 1'b1;
        efuse_addr_i  = 8'h40;
        efuse_aen_i   = 1'b0;
        step();
        efuse_aen_i = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", efuse_rdata_o, 8'h00);
        chk("midrst_err", {7'b0, err_o}, 8'h00);
        chk("midrst_code", {6'b0, err_code_o}, 8'h00);
        chk("midrst_done", {7'b0, pgm_done_o}, 8'h00);
        step();
        rst_n         = 1'b1;
        efuse_aen_i   = 1'b0;
        efuse_pgmen_i = 1'b0;
        repeat (2) step();
        chk("postrst_done", {7'b0, pgm_done_o}, 8'h00);
        rd(8'h10, 3, rdv);
        chk("postrst_init_b2", rdv, 8'h00);
        rd(8'h40, 3, rdv);
        chk("postrst_nowrite", rdv, 8'h00);
        rd(8'h00, 3, rdv);
        chk("postrst_init_b0", rdv, 8'hFF);
        chk("postrst_err", {7'b0, err_o}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/efuse_array_emu.md
# efuse_array_emu

Synthesizable emulation model of the 256-bit eFuse macro for FPGA prototyping and simulation. It sits on the macro side of the eFuse mux and responds to the registered strobes `efuse_pgmen_o`, `efuse_rden_o`, `efuse_aen_o` and `efuse_addr_o`, returning `efuse_rdata_i`. It enforces program and read pulse timing, applies one-time-programmable (0→1 only) semantics, and flags protocol violations, so the read and write controllers can be verified against a checking responder.

## Interface
- `TPGM_MIN`, default 8: minimum number of sampled-high `aen` cycles for a valid program pulse (≥2).
- `TRD`, default 2: read access latency in cycles from the `aen` rising sample (≥1).
- `INIT`, default 256'h0: array contents loaded at reset.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `efuse_pgmen_i`  in  1  program mode enable.
- `efuse_rden_i`  in  1  read mode enable.
- `efuse_aen_i`  in  1  access strobe.
- `efuse_addr_i`  in  8  bit address (program); addr[7:3] is the byte address (read).
- `efuse_rdata_o`  out  8  read data, registered.
- `pgm_done_o`  out  1  one-cycle pulse when a valid program pulse completes.
- `err_o`  out  1  sticky protocol-error flag.
- `err_code_o`  out  2  first error since clear: 01 mode conflict, 10 short strobe, 11 control change during strobe.
- `err_clr_i`  in  1  synchronous clear of `err_o` and `err_code_o`.

## Operation
- Storage is a 256-bit register `fuse`; `fuse` = `INIT` on reset. Bit `a` corresponds to address `a`. Read byte `b`: `rdata[i] = fuse[{b,i}]`, for i = 0..7.
- Rising-edge detect on `aen`: E is the first cycle with `aen` sampled 1 after a cycle with it sampled 0. At E, the block latches pgmen, rden and addr.
- FSM states: IDLE, PGM, RD, WAIT_LOW.
- IDLE, at E:
  - pgmen=1, rden=0 → PGM, with cnt=1.
  - pgmen=0, rden=1 → RD, with cnt=1.
  - Both 1 or both 0 → error 01, then WAIT_LOW.
- PGM: cnt increments each cycle while `aen` stays high, saturating at `TPGM_MIN`. On the first `aen`-low sample:
  - cnt ≥ `TPGM_MIN` → `fuse[addr_latched]` is set to 1, `pgm_done_o` pulses, then IDLE.
  - Otherwise → error 10, no write, then IDLE.
  - Programming a bit that is already 1 leaves it unchanged and still pulses done.
- RD: cnt increments while `aen` stays high.
  - When cnt reaches `TRD`, `efuse_rdata_o` loads byte `addr_latched[7:3]`. The state stays RD until `aen` goes low, then IDLE.
  - If `aen` goes low before cnt reaches `TRD` → error 10, `rdata` unchanged, then IDLE.
- In PGM or RD, any change of pgmen, rden or addr versus the latched values while `aen` is high → error 11, the operation is aborted with no write and no rdata update, then WAIT_LOW.
- WAIT_LOW: stays until `aen` is sampled 0, then IDLE.
- Errors:
  - `err_o` is set by any error.
  - `err_code_o` keeps the first code until cleared.
  - `err_clr_i` clears both. An error in the same cycle as a clear wins and loads its code.
- pgmen or rden toggling while `aen` is low is legal and ignored.

## Timing
- Reset values: `efuse_rdata_o`=0, `pgm_done_o`=0, `err_o`=0, `err_code_o`=0, FSM=IDLE, cnt=0, `fuse`=`INIT`.
- Read: `efuse_rdata_o` is valid from cycle E+`TRD` if `aen` is sampled high in cycles E..E+`TRD`−1. It holds until the next successful read or reset.
- Program: with `aen` first sampled low at cycle F (pulse width F−E):
  - the new bit is visible in `fuse` from F+1;
  - `pgm_done_o` is high only in cycle F+1.
- A read whose E is at or after F+1 returns the new bit.
- Errors: `err_o` and `err_code_o` update in the cycle after the violating sample.
- Reset mid-operation aborts it: no partial write, and `fuse` reloads `INIT`.
- Back-to-back: a new E may occur one cycle after the `aen`-low sample; IDLE accepts it.

## Test plan
- `INIT`=0. Program addr 0x13 with `aen` high for 8 cycles, then read addr 0x10 (`aen` high 3 cycles) → `pgm_done_o` pulses at F+1; `rdata`=0x08 at E+2; `err_o`=0.
- Program addr 0x13 with `aen` high for 7 cycles → error 10, bit stays 0; a later read of 0x10 returns 0x00.
- `INIT`=256'hFF at byte 0. Program addr 0x02 again, then read 0x00 → `pgm_done_o` pulses; `rdata`=0xFF (OTP, no clear).
- Assert `aen` with pgmen=rden=1 → `err_code_o`=01, no write. Assert `err_clr_i` → `err_o`=0. Then read byte 0 → normal data.
- Change addr from 0x20 to 0x21 at E+3 of a program pulse → `err_code_o`=11, `fuse` unchanged, no `pgm_done_o`, FSM waits for `aen` low.
- Assert `rst_n` low at E+4 of a program pulse, then release and read → `rdata` reflects `INIT`, all outputs at reset values.
